y86_mem_responder: RTL and testbench

Memory-side responder for the pipelined Y86-64 core: serves the fetch stage's instruction-byte requests and the memory stage's data read/write requests from one byte-addressed, little-endian array. Uses a valid/ready request handshake and a fixed-latency response pulse. Owns the single physical memory, so the core's fetch and memory units become initiators on this block instead of holding private arrays.

---
 rtl/y86_mem_responder.sv | 134 +++++++++++++
 tb/tb_y86_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_mem_responder.sv
// Shared instruction/data memory responder for the pipelined Y86-64 core, with a valid/ready request side and a fixed-latency response pulse.
// Optional build macro: MEMRESP_ALIGN_CHECK_EN (data requests with d_addr[2:0] != 0 respond with an error).
module y86_mem_responder #(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [63:0] i_addr,
  output logic        i_rsp_valid,
  output logic [79:0] i_rsp_data,
  output logic        i_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_rsp_valid,
  output logic [63:0] d_rsp_rdata,
  output logic        d_rsp_err
);

  localparam int          AW       = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [64:0] MEM_END  = 65'(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        sel_data_q;
  logic        we_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;

  logic        accept_d, accept_i, accept;
  logic        resp;
  logic        i_err_c, d_err_c, d_range_err;
  logic [AW-1:0] base;
  logic [79:0] rd_bytes;

  logic [7:0]  mem [MEM_BYTES];

  // Data port wins a tie: it belongs to the older instruction in the pipe.
  assign d_req_ready = !rst && (state == IDLE);
  assign i_req_ready = d_req_ready && !d_req_valid;
  assign accept_d    = d_req_valid && d_req_ready;
  assign accept_i    = i_req_valid && i_req_ready;
  assign accept      = accept_d || accept_i;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt   = CNT_LOAD;
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt_nxt == 4'd0) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      sel_data_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        sel_data_q <= accept_d;
        we_q       <= accept_d && d_req_we;
        addr_q     <= accept_d ? d_addr : i_addr;
        wdata_q    <= d_wdata;
      end
    end
  end

  // Bounds are checked with a 65-bit sum so addresses near 2^64 cannot wrap into range.
  assign i_err_c     = ({1'b0, addr_q} + 65'd10) > MEM_END;
  assign d_range_err = ({1'b0, addr_q} + 65'd8) > MEM_END;
`ifdef MEMRESP_ALIGN_CHECK_EN
  assign d_err_c = d_range_err || (addr_q[2:0] != 3'b000);
`else
  assign d_err_c = d_range_err;
`endif

  assign base = addr_q[AW-1:0];

  // Ten bytes cover the longest instruction; the data port uses the low eight.
  always_comb begin
    rd_bytes = '0;
    for (int k = 0; k < 10; k++) begin
      rd_bytes[8*k +: 8] = mem[base + AW'(k)];
    end
  end

  // NOTE: the array is deliberately left out of reset; memory contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && sel_data_q && we_q && !d_err_c) begin
      for (int k = 0; k < 8; k++) begin
        mem[base + AW'(k)] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign resp        = !rst && (state == RESP);
  assign d_rsp_valid = resp && sel_data_q;
  assign d_rsp_err   = d_rsp_valid && d_err_c;
  assign d_rsp_rdata = (d_rsp_valid && !d_err_c && !we_q) ? rd_bytes[63:0] : 64'd0;
  assign i_rsp_valid = resp && !sel_data_q;
  assign i_rsp_err   = i_rsp_valid && i_err_c;
  assign i_rsp_data  = (i_rsp_valid && !i_err_c) ? rd_bytes : 80'd0;

endmodule

// File: tb/tb_y86_mem_responder.sv
// Self-checking bench for y86_mem_responder: a transaction-level model checked every cycle, plus directed literal expectations.
module tb_y86_mem_responder;

  localparam int MEM_BYTES = 1024;
  localparam int LATENCY   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        i_req_ready;
  logic [63:0] i_addr = 64'd0;
  logic        i_rsp_valid;
  logic [79:0] i_rsp_data;
  logic        i_rsp_err;
  logic        d_req_valid = 1'b0;
  logic        d_req_ready;
  logic        d_req_we = 1'b0;
  logic [63:0] d_addr = 64'd0;
  logic [63:0] d_wdata = 64'd0;
  logic        d_rsp_valid;
  logic [63:0] d_rsp_rdata;
  logic        d_rsp_err;

  y86_mem_responder #(.MEM_BYTES(MEM_BYTES), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [7:0]  mmem [MEM_BYTES];
  bit          busy = 1'b0;
  int          rem  = 0;
  bit          p_is_data, p_we, p_err;
  logic [63:0] p_addr, p_wdata;
  bit          cmp_en = 1'b0;

  function automatic bit fetch_oob(input logic [63:0] a);
    return a > 64'(MEM_BYTES - 10);
  endfunction

  function automatic bit data_bad(input logic [63:0] a);
    bit bad;
    bad = a > 64'(MEM_BYTES - 8);
`ifdef MEMRESP_ALIGN_CHECK_EN
    if (a[2:0] != 3'b000) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [79:0] model_read(input logic [63:0] a, input int n);
    logic [79:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = mmem[int'(a) + k];
    return r;
  endfunction

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mmem[i] = 8'h00;
  end

  // A request occupies the responder for LATENCY cycles; its pulse is in the last of them.
  always @(posedge clk) begin
    if (rst) begin
      busy = 1'b0;
    end else if (busy) begin
      if (rem == 1) begin
        if (p_is_data && p_we && !p_err)
          for (int k = 0; k < 8; k++) mmem[int'(p_addr) + k] = p_wdata[8*k +: 8];
        busy = 1'b0;
      end else begin
        rem--;
      end
    end else if (d_req_valid) begin
      busy = 1'b1; rem = LATENCY; p_is_data = 1'b1; p_we = d_req_we;
      p_addr = d_addr; p_wdata = d_wdata; p_err = data_bad(d_addr);
    end else if (i_req_valid) begin
      busy = 1'b1; rem = LATENCY; p_is_data = 1'b0; p_we = 1'b0;
      p_addr = i_addr; p_wdata = 64'd0; p_err = fetch_oob(i_addr);
    end
  end

  bit          e_pulse, e_dv, e_iv;
  logic [79:0] e_ddata, e_idata;

  always @(negedge clk) begin
    if (cmp_en) begin
      e_pulse = !rst && busy && (rem == 1);
      e_dv    = e_pulse && p_is_data;
      e_iv    = e_pulse && !p_is_data;
      e_ddata = (e_dv && !p_err && !p_we) ? model_read(p_addr, 8) : 80'd0;
      e_idata = (e_iv && !p_err) ? model_read(p_addr, 10) : 80'd0;
      check("d_req_ready", 80'(d_req_ready), 80'(!rst && !busy));
      check("i_req_ready", 80'(i_req_ready), 80'(!rst && !busy && !d_req_valid));
      check("d_rsp_valid", 80'(d_rsp_valid), 80'(e_dv));
      check("d_rsp_rdata", 80'(d_rsp_rdata), e_ddata);
      check("d_rsp_err",   80'(d_rsp_err),   80'(e_dv && p_err));
      check("i_rsp_valid", 80'(i_rsp_valid), 80'(e_iv));
      check("i_rsp_data",  i_rsp_data,      e_idata);
      check("i_rsp_err",   80'(i_rsp_err),   80'(e_iv && p_err));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic txn(input bit is_data, input bit we, input logic [63:0] addr,
                     input logic [63:0] wdata, output logic [79:0] data,
                     output logic err, output int lat);
    bit got;
    data = '0; err = 1'b0; lat = -1;
    @(posedge clk); #1;
    if (is_data) begin
      d_req_valid = 1'b1; d_req_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req_valid = 1'b1; i_addr = addr;
    end
    got = 1'b0;
    for (int c = 0; c < 32 && !got; c++) begin
      @(negedge clk);
      got = is_data ? d_req_ready : i_req_ready;
      @(posedge clk); #1;
    end
    d_req_valid = 1'b0; i_req_valid = 1'b0;
    if (!got) begin
      check("accept_timeout", 80'd0, 80'd1);
      return;
    end
    got = 1'b0;
    for (int c = 1; c <= 32 && !got; c++) begin
      @(negedge clk);
      if (is_data ? d_rsp_valid : i_rsp_valid) begin
        got  = 1'b1;
        lat  = c;
        data = is_data ? {16'h0, d_rsp_rdata} : i_rsp_data;
        err  = is_data ? d_rsp_err : i_rsp_err;
      end
    end
    if (!got) check("rsp_timeout", 80'd0, 80'd1);
  endtask

  logic [79:0] data;
  logic        err;
  int          lat;
  int          d_seen, i_seen, pulses;
  bit          drop;

  initial begin
    rst = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_d_ready", 80'(d_req_ready), 80'd0);
    check("rst_i_ready", 80'(i_req_ready), 80'd0);
    check("rst_rsp", 80'({d_rsp_valid, i_rsp_valid, d_rsp_err, i_rsp_err}), 80'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_d_ready", 80'(d_req_ready), 80'd1);

    // Write then read back at 0x40
    txn(1, 1, 64'h40, 64'h1122334455667788, data, err, lat);
    check("wr40_lat", 80'(lat), 80'd2);
    check("wr40_err", 80'(err), 80'd0);
    txn(1, 0, 64'h40, 64'd0, data, err, lat);
    check("rd40_data", data, 80'h1122334455667788);
    check("rd40_byte0", 80'(data[7:0]), 80'h88);

    // Instruction bytes 30 F3 0A 00... at 0x20
    txn(1, 1, 64'h20, 64'h00000000000AF330, data, err, lat);
    txn(1, 1, 64'h28, 64'h0, data, err, lat);
    txn(0, 0, 64'h20, 64'd0, data, err, lat);
    check("f20_b0", 80'(data[7:0]), 80'h30);
    check("f20_b1", 80'(data[15:8]), 80'hF3);
    check("f20_b2", 80'(data[23:16]), 80'h0A);
    check("f20_err", 80'(err), 80'd0);
    check("f20_lat", 80'(lat), 80'd2);

    // Fetch range boundary
    txn(1, 1, 64'h3F0, 64'h0706050403020100, data, err, lat);
    txn(1, 1, 64'h3F8, 64'hFFEEDDCCBBAA9988, data, err, lat);
    txn(0, 0, 64'h3F6, 64'd0, data, err, lat);
    check("f3f6_data", data, 80'hFFEEDDCCBBAA99880706);
    check("f3f6_err", 80'(err), 80'd0);
    txn(0, 0, 64'h3F7, 64'd0, data, err, lat);
    check("f3f7_err", 80'(err), 80'd1);
    check("f3f7_data", data, 80'd0);

    // Write near 2^64 must not wrap into the array
    txn(1, 1, 64'h0, 64'hCAFEF00DDEADBEEF, data, err, lat);
    txn(1, 1, 64'hFFFFFFFFFFFFFFFC, 64'h123456789ABCDEF0, data, err, lat);
    check("wrap_err", 80'(err), 80'd1);
    txn(0, 0, 64'h3F6, 64'd0, data, err, lat);
    check("wrap_top_intact", data, 80'hFFEEDDCCBBAA99880706);
    txn(1, 0, 64'h0, 64'd0, data, err, lat);
    check("wrap_low_intact", data, 80'hCAFEF00DDEADBEEF);

    // Unaligned data read at 0x41
    txn(1, 1, 64'h48, 64'h0102030405060708, data, err, lat);
    txn(1, 0, 64'h41, 64'd0, data, err, lat);
`ifdef MEMRESP_ALIGN_CHECK_EN
    check("rd41_err", 80'(err), 80'd1);
    check("rd41_data", data, 80'd0);
`else
    check("rd41_err", 80'(err), 80'd0);
    check("rd41_data", data, 80'h0811223344556677);
`endif

    // Simultaneous fetch and data: data first, fetch in the next IDLE
    @(posedge clk); #1;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_addr = 64'h40;
    i_req_valid = 1'b1; i_addr = 64'h20;
    @(negedge clk);
    check("prio_d_ready", 80'(d_req_ready), 80'd1);
    check("prio_i_ready", 80'(i_req_ready), 80'd0);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    d_seen = 0; i_seen = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (d_rsp_valid && d_seen == 0) d_seen = c;
      if (i_rsp_valid && i_seen == 0) i_seen = c;
      drop = i_req_ready && i_req_valid;
      @(posedge clk); #1;
      if (drop) i_req_valid = 1'b0;
    end
    i_req_valid = 1'b0;
    check("prio_d_pulse_cycle", 80'(d_seen), 80'd2);
    check("prio_i_pulse_cycle", 80'(i_seen), 80'd5);

    // Reset during WAIT of a write to 0x80 drops it
    txn(1, 1, 64'h80, 64'hA5A5A5A5A5A5A5A5, data, err, lat);
    @(posedge clk); #1;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_addr = 64'h80; d_wdata = 64'h5A5A5A5A5A5A5A5A;
    @(negedge clk);
    check("rstwait_accept", 80'(d_req_ready), 80'd1);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (d_rsp_valid || i_rsp_valid) pulses++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    if (d_rsp_valid || i_rsp_valid) pulses++;
    check("rstwait_no_pulse", 80'(pulses), 80'd0);
    check("rstwait_d_ready", 80'(d_req_ready), 80'd1);
    check("rstwait_i_ready", 80'(i_req_ready), 80'd1);
    txn(1, 0, 64'h80, 64'd0, data, err, lat);
    check("rstwait_byte80", 80'(data[7:0]), 80'hA5);
    check("rstwait_word80", data, 80'hA5A5A5A5A5A5A5A5);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
